// File: rtl/core_s1_fetch_ctrl.sv
// core_s1_fetch_ctrl: stage-1 fetch sequencer with a one-entry skid buffer toward s2 and branch squash.
module core_s1_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_illegal,
  input  logic        s2_ready,
  input  logic        branch_en,
  input  logic [31:0] branch_target_addr,
  output logic        s1_to_s2_valid,
  output logic [31:0] s1_to_s2_pc,
  output logic [31:0] s1_to_s2_instr,
  output logic        s1_to_s2_illegal
);
  typedef enum logic [1:0] {WAIT, REQ, SQUASH, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, sq_addr_q, sq_addr_d, buf_pc_q, buf_instr_q;
  logic        buf_valid_q, buf_illegal_q, capture, pending;
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT;
    else     state_q <= state_d;
  end
  // A request left unanswered at a branch must still be drained, so it moves to SQUASH.
  always_comb begin
    state_d   = state_q;
    sq_addr_d = sq_addr_q;
    if (state_q == SQUASH)  state_d = imem_rsp_ready ? WAIT : SQUASH;
    else if (branch_en)     state_d = pending ? SQUASH : WAIT;
    else if (capture)       state_d = imem_rsp_illegal ? HALT : WAIT;
    else if (pending)       state_d = REQ;
    if (branch_en && pending) sq_addr_d = pc_q;
    pc_d = branch_en ? (branch_target_addr & ~32'h3) : capture ? pc_q + 32'd4 : pc_q;
  end
  always_comb begin
    imem_req_valid = !rst && (state_q == WAIT ? (!buf_valid_q || s2_ready) : state_q != HALT);
    imem_req_addr  = state_q == SQUASH ? sq_addr_q : pc_q;
    capture        = imem_req_valid && imem_rsp_ready && !branch_en && (state_q == WAIT || state_q == REQ);
    pending        = imem_req_valid && !imem_rsp_ready && (state_q == WAIT || state_q == REQ);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      sq_addr_q     <= '0;
      buf_valid_q   <= 1'b0;
      buf_pc_q      <= '0;
      buf_instr_q   <= '0;
      buf_illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      sq_addr_q <= sq_addr_d;
      if (branch_en) buf_valid_q <= 1'b0;
      else if (capture) begin
        buf_valid_q   <= 1'b1;
        buf_pc_q      <= pc_q;
        buf_instr_q   <= imem_rsp_data;
        buf_illegal_q <= imem_rsp_illegal;
      end else if (buf_valid_q && s2_ready) buf_valid_q <= 1'b0;
    end
  end
  assign s1_to_s2_valid   = buf_valid_q;
  assign s1_to_s2_pc      = buf_pc_q;
  assign s1_to_s2_instr   = buf_instr_q;
  assign s1_to_s2_illegal = buf_valid_q & buf_illegal_q;
endmodule

// File: tb/tb_core_s1_fetch_ctrl.sv
// tb_core_s1_fetch_ctrl: directed cycle-by-cycle checks of the fetch sequencer against hand-derived values.
module tb_core_s1_fetch_ctrl;
  logic        clk = 0, rst = 1;
  logic        imem_req_valid, imem_rsp_ready = 0, imem_rsp_illegal = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0, branch_target_addr = 0;
  logic        s2_ready = 1, branch_en = 0;
  logic        s1_to_s2_valid, s1_to_s2_illegal;
  logic [31:0] s1_to_s2_pc, s1_to_s2_instr;
  int errors = 0, checks = 0;
  core_s1_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data), .imem_rsp_illegal(imem_rsp_illegal),
    .s2_ready(s2_ready), .branch_en(branch_en), .branch_target_addr(branch_target_addr),
    .s1_to_s2_valid(s1_to_s2_valid), .s1_to_s2_pc(s1_to_s2_pc),
    .s1_to_s2_instr(s1_to_s2_instr), .s1_to_s2_illegal(s1_to_s2_illegal)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rsp(input logic r, input logic [31:0] d);
    imem_rsp_ready = r;
    imem_rsp_data  = d;
  endtask
  initial begin
    tick();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_out_valid", 32'(s1_to_s2_valid), 0);
    chk("rst_out_ill", 32'(s1_to_s2_illegal), 0);
    chk("rst_out_pc", s1_to_s2_pc, 0);
    chk("rst_out_instr", s1_to_s2_instr, 0);
    tick();
    rst = 0;
    rsp(1, ins(32'h0)); #1;
    chk("c0_req_valid", 32'(imem_req_valid), 1);
    chk("c0_addr", imem_req_addr, 32'h0);
    chk("c0_out_valid", 32'(s1_to_s2_valid), 0);
    tick();
    rsp(1, ins(32'h4)); #1;
    chk("c1_addr", imem_req_addr, 32'h4);
    chk("c1_out_valid", 32'(s1_to_s2_valid), 1);
    chk("c1_out_pc", s1_to_s2_pc, 32'h0);
    chk("c1_out_instr", s1_to_s2_instr, ins(32'h0));
    tick();
    rsp(1, ins(32'h8)); #1;
    chk("c2_addr", imem_req_addr, 32'h8);
    chk("c2_out_pc", s1_to_s2_pc, 32'h4);
    tick();
    s2_ready = 0; rsp(0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req_valid", 32'(imem_req_valid), 0);
      chk("stall_out_valid", 32'(s1_to_s2_valid), 1);
      chk("stall_out_pc", s1_to_s2_pc, 32'h8);
      chk("stall_out_instr", s1_to_s2_instr, ins(32'h8));
      tick();
    end
    s2_ready = 1; rsp(1, ins(32'hC)); #1;
    chk("drain_req_valid", 32'(imem_req_valid), 1);
    chk("drain_addr", imem_req_addr, 32'hC);
    tick();
    rsp(0, 0); #1;
    chk("refill_out_pc", s1_to_s2_pc, 32'hC);
    chk("lat_req_addr", imem_req_addr, 32'h10);
    tick();
    branch_en = 1; branch_target_addr = 32'h100; #1;
    chk("req_hold_valid", 32'(imem_req_valid), 1);
    chk("req_hold_addr", imem_req_addr, 32'h10);
    tick();
    branch_en = 0; rsp(1, ins(32'h10)); #1;
    chk("squash_valid", 32'(imem_req_valid), 1);
    chk("squash_addr", imem_req_addr, 32'h10);
    tick();
    rsp(1, ins(32'h100)); #1;
    chk("post_squash_out_valid", 32'(s1_to_s2_valid), 0);
    chk("target_addr", imem_req_addr, 32'h100);
    tick();
    rsp(1, ins(32'h104)); branch_en = 1; branch_target_addr = 32'h203; #1;
    chk("target_out_pc", s1_to_s2_pc, 32'h100);
    chk("coinc_addr", imem_req_addr, 32'h104);
    tick();
    branch_en = 0; rsp(1, ins(32'h200)); #1;
    chk("coinc_out_valid", 32'(s1_to_s2_valid), 0);
    chk("aligned_target", imem_req_addr, 32'h200);
    tick();
    rsp(1, 32'hBAD0_BAD0); imem_rsp_illegal = 1; #1;
    chk("pre_ill_addr", imem_req_addr, 32'h204);
    chk("pre_ill_flag", 32'(s1_to_s2_illegal), 0);
    tick();
    rsp(0, 0); imem_rsp_illegal = 0; s2_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) s2_ready = 1;
      #1;
      chk("halt_req_valid", 32'(imem_req_valid), 0);
      if (i < 3) begin
        chk("halt_out_valid", 32'(s1_to_s2_valid), 1);
        chk("halt_out_ill", 32'(s1_to_s2_illegal), 1);
        chk("halt_out_pc", s1_to_s2_pc, 32'h204);
      end else chk("halt_drained", 32'(s1_to_s2_valid), 0);
      tick();
    end
    branch_en = 1; branch_target_addr = 32'h40; #1;
    chk("halt_branch_req", 32'(imem_req_valid), 0);
    tick();
    branch_en = 0; #1;
    chk("resume_valid", 32'(imem_req_valid), 1);
    chk("resume_addr", imem_req_addr, 32'h40);
    chk("resume_out_ill", 32'(s1_to_s2_illegal), 0);
    tick();
    rst = 1; #1;
    chk("rst_mid_req_valid", 32'(imem_req_valid), 0);
    tick();
    rst = 0; #1;
    chk("rerst_addr", imem_req_addr, 32'h0);
    chk("rerst_valid", 32'(imem_req_valid), 1);
    chk("rerst_out_valid", 32'(s1_to_s2_valid), 0);
    branch_en = 1; branch_target_addr = 32'hFFFF_FFFF; rsp(1, ins(32'h0));
    tick();
    branch_en = 0; rsp(1, ins(32'hFFFF_FFFC)); #1;
    chk("wrap_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    rsp(0, 0); #1;
    chk("wrap_out_pc", s1_to_s2_pc, 32'hFFFF_FFFC);
    chk("wrap_out_instr", s1_to_s2_instr, ins(32'hFFFF_FFFC));
    chk("wrap_addr_zero", imem_req_addr, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
